// File: rtl/mc_rf_timer_pkg.sv
// mc_pkg: shared definitions for the memory-controller refresh timer.
//   mc_rf_state_e    : timer state (DIS = disabled, RUN = counting, HOLD = period is zero)
//   MC_RF_MAX_PEND   : default saturation level of the pending-refresh count
//   MC_RF_URGENT_TH  : default pending level at which refresh becomes urgent
package mc_pkg;

   typedef enum logic [1:0] {
      DIS  = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } mc_rf_state_e;

   localparam int MC_RF_MAX_PEND  = 8;
   localparam int MC_RF_URGENT_TH = 4;

endpackage

// File: rtl/mc_rf_period_cnt.sv
// mc_rf_period_cnt: loadable refresh-period down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : cnt <= load_val, no tick this cycle (wins over en)
//   en         : count this cycle; at cnt <= 1 reload from load_val and tick
//   load_val   : reload / load value (the selected period)
//   tick       : one-cycle strobe, one refresh interval elapsed
module mc_rf_period_cnt
   import mc_pkg::*;
#(
   parameter int CNT_WIDTH = 25
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] load_val,
   output logic                 tick
);

   logic [CNT_WIDTH-1:0] cnt;

   assign tick = en && !load && (cnt <= CNT_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en)
         cnt <= tick ? load_val : cnt - 1'b1;
   end

endmodule

// File: rtl/mc_rf_timer.sv
// mc_rf_timer: refresh-interval timer. Ticks every selected period while
// enabled, accumulates ticks as pending refreshes, drains them on rf_ack.
//   apb_pclk, apb_prst_n : clock, asynchronous active-low reset
//   mc_en                : controller enable
//   array_rf_period_0/1  : refresh periods in cycles; array_rf_period_sel picks one
//   rf_ack               : one refresh issued by the scheduler
//   rf_req               : at least one refresh pending
//   rf_urgent            : pending >= URGENT_TH
//   rf_pending           : outstanding refresh count (saturates at MAX_PEND)
//   rf_overflow          : sticky, a tick arrived while pending was saturated
module mc_rf_timer
   import mc_pkg::*;
#(
   parameter int CNT_WIDTH  = 25,
   parameter int PEND_WIDTH = 4,
   parameter int MAX_PEND   = MC_RF_MAX_PEND,
   parameter int URGENT_TH  = MC_RF_URGENT_TH
) (
   input  logic                  apb_pclk,
   input  logic                  apb_prst_n,
   input  logic                  mc_en,
   input  logic [CNT_WIDTH-1:0]  array_rf_period_0,
   input  logic [CNT_WIDTH-1:0]  array_rf_period_1,
   input  logic                  array_rf_period_sel,
   input  logic                  rf_ack,
   output logic                  rf_req,
   output logic                  rf_urgent,
   output logic [PEND_WIDTH-1:0] rf_pending,
   output logic                  rf_overflow
);

   mc_rf_state_e          state, state_nxt;
   logic [CNT_WIDTH-1:0]  period, load_val;
   logic                  sel_q, sel_tgl, p_zero;
   logic                  start, load, cnt_en, cnt_tick, tick, ack_ok;
   logic [PEND_WIDTH-1:0] pending;
   logic                  overflow;

   assign period  = array_rf_period_sel ? array_rf_period_1 : array_rf_period_0;
   assign p_zero  = (period == '0);
   assign sel_tgl = array_rf_period_sel ^ sel_q;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      cnt_en    = 1'b0;
      start     = 1'b0;
      if (!mc_en) begin
         state_nxt = DIS;
         load      = 1'b1;
      end else begin
         case (state)
            DIS: begin
               if (p_zero)
                  state_nxt = HOLD;
               else begin
                  state_nxt = RUN;
                  load      = 1'b1;
                  start     = 1'b1;
               end
            end
            RUN: begin
               if (p_zero)
                  state_nxt = HOLD;
               else if (sel_tgl)
                  load = 1'b1;
               else
                  cnt_en = 1'b1;
            end
            HOLD: begin
               if (!p_zero) begin
                  state_nxt = RUN;
                  load      = 1'b1;
               end
            end
            default: state_nxt = DIS;
         endcase
      end
   end

   // The enabling edge already counts as the first cycle of the period, so
   // the first tick lands on the P-th enabled edge: start loads P-1, and
   // for P=1 the tick is issued on the enabling edge itself.
   assign load_val = (start && period > CNT_WIDTH'(1)) ? period - 1'b1 : period;
   assign tick     = cnt_tick || (start && period == CNT_WIDTH'(1));
   assign ack_ok   = rf_ack && (pending != '0);

   mc_rf_period_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk      (apb_pclk),
      .rst_n    (apb_prst_n),
      .load     (load),
      .en       (cnt_en),
      .load_val (load_val),
      .tick     (cnt_tick)
   );

   always_ff @(posedge apb_pclk or negedge apb_prst_n) begin
      if (!apb_prst_n) begin
         state <= DIS;
         sel_q <= 1'b0;
      end else begin
         state <= state_nxt;
         sel_q <= array_rf_period_sel;
      end
   end

   always_ff @(posedge apb_pclk or negedge apb_prst_n) begin
      if (!apb_prst_n) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else if (!mc_en) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else if (tick && !ack_ok) begin
         if (pending == PEND_WIDTH'(MAX_PEND))
            overflow <= 1'b1;
         else
            pending <= pending + 1'b1;
      end else if (ack_ok && !tick) begin
         pending <= pending - 1'b1;
      end
   end

   assign rf_pending  = pending;
   assign rf_req      = (pending != '0);
   assign rf_urgent   = (pending >= PEND_WIDTH'(URGENT_TH));
   assign rf_overflow = overflow;

endmodule

// File: tb/tb_mc_rf_timer.sv
module tb_mc_rf_timer;
   localparam int CW = 25;
   localparam int PW = 4;
   localparam int MAXP = 8;
   localparam int URG = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mc_en = 1'b0;
   logic          sel = 1'b0;
   logic          ack = 1'b0;
   logic [CW-1:0] p0 = '0;
   logic [CW-1:0] p1 = '0;
   logic          req, urg, ovf;
   logic [PW-1:0] pend;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mc_rf_timer #(.CNT_WIDTH(CW), .PEND_WIDTH(PW), .MAX_PEND(MAXP), .URGENT_TH(URG)) dut (
      .apb_pclk            (clk),
      .apb_prst_n          (rst_n),
      .mc_en               (mc_en),
      .array_rf_period_0   (p0),
      .array_rf_period_1   (p1),
      .array_rf_period_sel (sel),
      .rf_ack              (ack),
      .rf_req              (req),
      .rf_urgent           (urg),
      .rf_pending          (pend),
      .rf_overflow         (ovf)
   );

   // Reference model: refresh ticks are scheduled as absolute edge numbers.
   int n = 0;        // edge number
   int m_next = 0;   // edge number of the next scheduled tick
   bit m_run = 0, m_hold = 0, m_ovf = 0, m_selq = 0;
   int m_pend = 0;

   task automatic model_reset();
      m_run = 0; m_hold = 0; m_ovf = 0; m_selq = 0; m_pend = 0;
   endtask

   task automatic model_step();
      int p;
      bit tk, ackv;
      p    = sel ? int'(p1) : int'(p0);
      tk   = 0;
      ackv = ack && (m_pend != 0);
      if (!mc_en) begin
         m_run = 0; m_hold = 0; m_pend = 0; m_ovf = 0;
      end else begin
         if (m_hold) begin
            if (p != 0) begin m_hold = 0; m_run = 1; m_next = n + p; end
         end else if (m_run) begin
            if (p == 0) begin m_run = 0; m_hold = 1; end
            else if (sel != m_selq) m_next = n + p;
            else if (n == m_next) begin tk = 1; m_next = n + p; end
         end else begin
            if (p == 0) m_hold = 1;
            else begin
               m_run = 1; m_next = n + p - 1;
               if (n == m_next) begin tk = 1; m_next = n + p; end
            end
         end
         if (tk && !ackv) begin
            if (m_pend == MAXP) m_ovf = 1;
            else m_pend++;
         end else if (ackv && !tk) begin
            m_pend--;
         end
      end
      m_selq = sel;
      n++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      chk("model_pending", 32'(pend), 32'(m_pend));
      chk("model_req", 32'(req), 32'(m_pend != 0));
      chk("model_urgent", 32'(urg), 32'(m_pend >= URG));
      chk("model_overflow", 32'(ovf), 32'(m_ovf));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pending"}, 32'(pend), 0);
      chk({tag, "_req"}, 32'(req), 0);
      chk({tag, "_urgent"}, 32'(urg), 0);
      chk({tag, "_overflow"}, 32'(ovf), 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      chk_model();
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) cyc();
   endtask

   task automatic ack_cyc();
      ack = 1'b1;
      cyc();
      ack = 1'b0;
   endtask

   initial begin
      // reset state
      #3;
      chk_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // P0=5: pending 1,2,3,4 every 5 edges, urgent at 4
      p0 = 5; p1 = 3; sel = 0; mc_en = 1;
      run(4);  chk("req_before_5th", 32'(req), 0);
      run(1);  chk("req_at_5th", 32'(req), 1); chk("pend_1", 32'(pend), 1);
      run(5);  chk("pend_2", 32'(pend), 2);
      run(5);  chk("pend_3", 32'(pend), 3); chk("urg_at_3", 32'(urg), 0);
      run(5);  chk("pend_4", 32'(pend), 4); chk("urg_at_4", 32'(urg), 1);
      run(20); chk("pend_8", 32'(pend), 8); chk("ovf_before", 32'(ovf), 0);
      run(5);  chk("pend_sat", 32'(pend), 8); chk("ovf_set", 32'(ovf), 1);
      mc_en = 0;
      run(1);  chk_zero("disable");

      // ack coinciding with tick, ack at zero
      mc_en = 1;
      run(5);  chk("pend_1b", 32'(pend), 1);
      run(4);
      ack_cyc(); chk("ack_with_tick", 32'(pend), 1);
      ack_cyc(); chk("ack_drain", 32'(pend), 0);
      ack_cyc(); chk("ack_at_zero", 32'(pend), 0);

      // select toggle mid-count
      mc_en = 0; run(1);
      p0 = 100; p1 = 3; mc_en = 1;
      run(40);
      sel = 1;
      cyc();   chk("tgl_edge", 32'(pend), 0);
      run(2);  chk("tgl_plus2", 32'(pend), 0);
      run(1);  chk("tgl_plus3", 32'(pend), 1);
      run(3);  chk("tgl_plus6", 32'(pend), 2);

      // period zero -> HOLD, acks still drain
      p0 = 4; sel = 0;
      cyc();   chk("tgl_back", 32'(pend), 2);
      run(8);  chk("pend_4b", 32'(pend), 4);
      p0 = 0;
      cyc();   chk("hold_entry", 32'(pend), 4);
      for (int i = 0; i < 50; i++) begin
         if (i == 10 || i == 30) ack_cyc();
         else cyc();
      end
      chk("hold_drain", 32'(pend), 2);
      p0 = 4;
      run(4);  chk("resume_early", 32'(pend), 2);
      run(1);  chk("resume_tick", 32'(pend), 3);
      run(4);  chk("resume_tick2", 32'(pend), 4);
      run(8);  chk("pend_6", 32'(pend), 6);

      // asynchronous reset mid-operation
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_zero("async_rst");
      @(posedge clk);
      #1;
      chk_zero("rst_held");
      rst_n = 1'b1;
      run(3);  chk("post_rst_early", 32'(pend), 0);
      run(1);  chk("post_rst_tick", 32'(pend), 1);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         mc_en = ($urandom_range(0, 59) != 0);
         ack   = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 29) == 0) sel = ~sel;
         if ($urandom_range(0, 39) == 0) p0 = CW'($urandom_range(0, 6));
         if ($urandom_range(0, 39) == 0) p1 = CW'($urandom_range(0, 6));
         cyc();
      end
      ack = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
